// File: rtl/stream_fifo_with_overflow.sv
// Show-ahead FIFO that absorbs a stream with no backpressure and hands it to a valid/ready consumer.
// A word that arrives while the FIFO is full and nothing is popped is dropped and latched into a sticky overflow flag.
module stream_fifo_with_overflow #(
  parameter int width             = 8,
  parameter int depth             = 8,
  parameter int almost_full_level = depth - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_valid,
  input  logic [width-1:0]           up_data,
  output logic                       down_valid,
  input  logic                       down_ready,
  output logic [width-1:0]           down_data,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow
);

  localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
  localparam int cnt_w = $clog2(depth + 1);

  localparam logic [ptr_w-1:0] last_ptr  = ptr_w'(depth - 1);
  localparam logic [cnt_w-1:0] depth_cnt = cnt_w'(depth);
  localparam logic [cnt_w-1:0] af_cnt    = cnt_w'(almost_full_level);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;

  // Pointers wrap explicitly so that depths other than powers of two work.
  function automatic logic [ptr_w-1:0] wrap_inc(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + ptr_w'(1);
  endfunction

  // Status flags decode only the registered count, so none of them has a path from the inputs.
  assign empty       = (count == '0);
  assign full        = (count == depth_cnt);
  assign almost_full = (count >= af_cnt);
  assign down_valid  = !empty;
  assign down_data   = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept the incoming word.
  assign pop  = down_valid && down_ready;
  assign push = up_valid && (!full || pop);
  assign drop = up_valid && full && !pop;

  // The storage array has no reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= up_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + cnt_w'(1);
        2'b01:   count <= count - cnt_w'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_fifo_with_overflow.sv
// Bench for stream_fifo_with_overflow: a depth-8 and a depth-5 instance, each checked against a queue model.
module tb_stream_fifo_with_overflow;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // depth-8 instance
  logic       up_valid8 = 1'b0;
  logic [7:0] up_data8 = '0;
  logic       down_ready8 = 1'b0;
  logic       down_valid8;
  logic [7:0] down_data8;
  logic [3:0] count8;
  logic       empty8, full8, af8, ovf8;

  // depth-5 instance
  logic       up_valid5 = 1'b0;
  logic [7:0] up_data5 = '0;
  logic       down_ready5 = 1'b0;
  logic       down_valid5;
  logic [7:0] down_data5;
  logic [2:0] count5;
  logic       empty5, full5, af5, ovf5;

  stream_fifo_with_overflow #(.width(8), .depth(8)) dut8 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid8), .up_data(up_data8),
    .down_valid(down_valid8), .down_ready(down_ready8), .down_data(down_data8),
    .count(count8), .empty(empty8), .full(full8), .almost_full(af8), .overflow(ovf8)
  );

  stream_fifo_with_overflow #(.width(8), .depth(5)) dut5 (
    .clk(clk), .rst(rst),
    .up_valid(up_valid5), .up_data(up_data5),
    .down_valid(down_valid5), .down_ready(down_ready5), .down_data(down_data5),
    .count(count5), .empty(empty5), .full(full5), .almost_full(af5), .overflow(ovf5)
  );

  // Behavioural model: a bounded queue plus a sticky drop flag.
  logic [7:0] mq8[$];
  logic [7:0] mq5[$];
  logic       movf8 = 1'b0;
  logic       movf5 = 1'b0;
  logic [7:0] got8[$];
  logic [7:0] got5[$];
  int         got5_cyc[$];
  int         cyc = 0;

  task automatic model_clear();
    mq8.delete(); mq5.delete();
    got8.delete(); got5.delete(); got5_cyc.delete();
    movf8 = 1'b0; movf5 = 1'b0;
  endtask

  // One clock on the depth-8 instance; inputs applied here, state observed #1 after the edge.
  task automatic step8(input logic v, input logic [7:0] d, input logic r);
    bit was_full, mpop;
    up_valid8 = v; up_data8 = d; down_ready8 = r;
    if (down_valid8 && r) got8.push_back(down_data8);
    was_full = (mq8.size() == 8);
    mpop = (mq8.size() > 0) && r;
    if (mpop) void'(mq8.pop_front());
    if (v) begin
      if (!was_full || mpop) mq8.push_back(d);
      else movf8 = 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic step5(input logic v, input logic [7:0] d, input logic r);
    bit was_full, mpop;
    up_valid5 = v; up_data5 = d; down_ready5 = r;
    if (down_valid5 && r) begin
      got5.push_back(down_data5);
      got5_cyc.push_back(cyc);
    end
    was_full = (mq5.size() == 5);
    mpop = (mq5.size() > 0) && r;
    if (mpop) void'(mq5.pop_front());
    if (v) begin
      if (!was_full || mpop) mq5.push_back(d);
      else movf5 = 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    up_valid8 = 1'b0; down_ready8 = 1'b0; up_valid5 = 1'b0; down_ready5 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({down_valid8, empty8, full8, af8, ovf8, count8} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset8: dv/empty/full/af/ovf/count got %b%b%b%b%b %0d required 01000 0",
               down_valid8, empty8, full8, af8, ovf8, count8);
    end
    checks++;
    if ({down_valid5, empty5, full5, af5, ovf5, count5} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset5: dv/empty/full/af/ovf/count got %b%b%b%b%b %0d required 01000 0",
               down_valid5, empty5, full5, af5, ovf5, count5);
    end
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_basic();
    logic [7:0] exp_b[3];
    exp_b = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) step8(1'b1, exp_b[i], 1'b0);
    step8(1'b0, 8'h00, 1'b0);
    checks++;
    if (count8 !== 4'd3 || down_data8 !== 8'h11 || empty8 !== 1'b0 || down_valid8 !== 1'b1) begin
      errors++;
      $display("FAIL basic_fill: count=%0d data=%h empty=%b dv=%b required 3 11 0 1",
               count8, down_data8, empty8, down_valid8);
    end
    for (int i = 0; i < 3; i++) step8(1'b0, 8'h00, 1'b1);
    down_ready8 = 1'b0;
    checks++;
    if (got8.size() != 3) begin
      errors++;
      $display("FAIL basic_drain_len: got %0d words required 3", got8.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got8[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL basic_order[%0d]: got %h required %h", i, got8[i], exp_b[i]);
        end
      end
    end
    checks++;
    if (empty8 !== 1'b1 || count8 !== 4'd0 || down_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_empty: empty=%b count=%0d dv=%b required 1 0 0", empty8, count8, down_valid8);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step8(1'b1, 8'(i), 1'b0);
      checks++;
      if (count8 !== 4'(i + 1) || af8 !== ((i + 1) >= 6)) begin
        errors++;
        $display("FAIL fill_af[%0d]: count=%0d af=%b required %0d %b", i, count8, af8, i + 1, (i + 1) >= 6);
      end
    end
    checks++;
    if (full8 !== 1'b1 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: full=%b ovf=%b required 1 0", full8, ovf8);
    end
    step8(1'b1, 8'hAA, 1'b0);
    up_valid8 = 1'b0;
    checks++;
    if (ovf8 !== 1'b1 || count8 !== 4'd8 || full8 !== 1'b1) begin
      errors++;
      $display("FAIL drop: ovf=%b count=%0d full=%b required 1 8 1", ovf8, count8, full8);
    end
    for (int i = 0; i < 9; i++) step8(1'b0, 8'h00, 1'b1);
    down_ready8 = 1'b0;
    checks++;
    if (got8.size() != 8 || ovf8 !== 1'b1 || empty8 !== 1'b1) begin
      errors++;
      $display("FAIL drop_drain: words=%0d ovf=%b empty=%b required 8 1 1", got8.size(), ovf8, empty8);
    end
    for (int i = 0; i < got8.size() && i < 8; i++) begin
      checks++;
      if (got8[i] !== 8'(i)) begin
        errors++;
        $display("FAIL drop_order[%0d]: got %h required %h", i, got8[i], 8'(i));
      end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) step8(1'b1, 8'(i), 1'b0);
    step8(1'b1, 8'hBB, 1'b1);
    up_valid8 = 1'b0;
    checks++;
    if (count8 !== 4'd8 || ovf8 !== 1'b0 || full8 !== 1'b1) begin
      errors++;
      $display("FAIL full_pushpop: count=%0d ovf=%b full=%b required 8 0 1", count8, ovf8, full8);
    end
    for (int i = 0; i < 8; i++) step8(1'b0, 8'h00, 1'b1);
    down_ready8 = 1'b0;
    checks++;
    if (got8.size() != 9) begin
      errors++;
      $display("FAIL full_pushpop_len: got %0d words required 9", got8.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (got8[i] !== ((i == 8) ? 8'hBB : 8'(i))) begin
          errors++;
          $display("FAIL full_pushpop_order[%0d]: got %h required %h", i, got8[i], (i == 8) ? 8'hBB : 8'(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int start;
    do_reset();
    start = cyc;
    for (int i = 0; i < 22; i++) step5(i < 20, 8'(i + 1), 1'b1);
    up_valid5 = 1'b0; down_ready5 = 1'b0;
    checks++;
    if (got5.size() != 20) begin
      errors++;
      $display("FAIL b2b_len: got %0d words required 20", got5.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (got5[i] !== 8'(i + 1) || got5_cyc[i] != start + 1 + i) begin
          errors++;
          $display("FAIL b2b[%0d]: got %h at cycle %0d required %h at cycle %0d",
                   i, got5[i], got5_cyc[i], 8'(i + 1), start + 1 + i);
        end
      end
    end
    checks++;
    if (empty5 !== 1'b1 || count5 !== 3'd0 || ovf5 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: empty=%b count=%0d ovf=%b required 1 0 0", empty5, count5, ovf5);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic v, r, stall_ok;
      logic [7:0] hold;
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 50);
      stall_ok = down_valid8 && !r;
      hold = down_data8;
      step8(v, 8'($urandom), r);
      checks++;
      if (count8 !== 4'(mq8.size()) || full8 !== (mq8.size() == 8) || empty8 !== (mq8.size() == 0) ||
          af8 !== (mq8.size() >= 6) || ovf8 !== movf8 || down_valid8 !== (mq8.size() != 0)) begin
        errors++;
        $display("FAIL rand_status[%0d]: count=%0d full=%b empty=%b af=%b ovf=%b dv=%b required count=%0d ovf=%b",
                 n, count8, full8, empty8, af8, ovf8, down_valid8, mq8.size(), movf8);
      end
      if (mq8.size() != 0) begin
        checks++;
        if (down_data8 !== mq8[0]) begin
          errors++;
          $display("FAIL rand_data[%0d]: got %h required %h", n, down_data8, mq8[0]);
        end
      end
      if (stall_ok) begin
        checks++;
        if (down_data8 !== hold) begin
          errors++;
          $display("FAIL rand_stall[%0d]: head changed to %h while stalled, required %h", n, down_data8, hold);
        end
      end
    end
    up_valid8 = 1'b0; down_ready8 = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 9; i++) step8(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 4; i++) step8(1'b0, 8'h00, 1'b1);
    down_ready8 = 1'b0;
    checks++;
    if (count8 !== 4'd4 || ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL arst_setup: count=%0d ovf=%b required 4 1", count8, ovf8);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({down_valid8, empty8, full8, af8, ovf8, count8} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL arst_immediate: dv/empty/full/af/ovf/count got %b%b%b%b%b %0d required 01000 0",
               down_valid8, empty8, full8, af8, ovf8, count8);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
    step8(1'b1, 8'h5C, 1'b0);
    up_valid8 = 1'b0;
    checks++;
    if (down_valid8 !== 1'b1 || down_data8 !== 8'h5C || count8 !== 4'd1) begin
      errors++;
      $display("FAIL arst_first_word: dv=%b data=%h count=%0d required 1 5c 1", down_valid8, down_data8, count8);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_fifo_with_overflow.md
# stream_fifo_with_overflow

Show-ahead FIFO that sits directly downstream of the valid-only circular delay buffer. It absorbs that buffer's `out_valid`/`out_data` stream, which has no backpressure, and presents it to a consumer through a valid/ready handshake. Occupancy and almost-full status let the controller throttle the producer. A sticky overflow flag reports any word lost because the FIFO was full.

## Interface
- `width`, default 8: data word width in bits.
- `depth`, default 8: number of storage entries; any integer ≥ 2, not necessarily a power of two.
- `almost_full_level`, default depth-2: `almost_full` asserts when count ≥ this value; legal range 1..depth.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0); released synchronously by the integrating logic.
- `up_valid`  in  1: upstream word present this cycle (driven by the delay buffer's `out_valid`).
- `up_data`  in  width: upstream word.
- `down_valid`  out  1: head word available; equals !empty.
- `down_ready`  in  1: consumer accepts the head word this cycle.
- `down_data`  out  width: head word; meaningful only while `down_valid`=1.
- `count`  out  $clog2(depth+1): current occupancy, 0..depth.
- `empty`  out  1: count == 0.
- `full`  out  1: count == depth.
- `almost_full`  out  1: count ≥ almost_full_level.
- `overflow`  out  1: sticky; set when a word is dropped; cleared only by reset.

## Operation
- Storage: `depth`-entry array plus a write pointer, a read pointer and an occupancy counter. Each pointer is $clog2(depth) bits wide and wraps explicitly from depth-1 to 0, which supports non-power-of-two depth.
- pop = `down_valid` && `down_ready`. Ready while empty has no effect.
- push = `up_valid` && (!full || pop). Pushing while full is allowed when a pop happens in the same cycle, because the freed slot is reused.
- drop = `up_valid` && full && !pop. The word is discarded, no state changes except `overflow` ← 1, and the pointers and count are unchanged.
- On push: mem[wr_ptr] ← `up_data`; wr_ptr advances with wrap.
- On pop: rd_ptr advances with wrap.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. count is never outside 0..depth.
- Push and pop together when empty: impossible, because pop requires `down_valid`. The pushed word becomes the head next cycle.
- `down_data` = mem[rd_ptr], read combinationally (show-ahead / first-word-fall-through after one cycle of write latency).
- `empty`, `full` and `almost_full` are decoded from the registered count. They are glitch-free relative to `clk` and carry no combinational path from the inputs.
- Reset (`rst`=0 at any time, including mid-transfer): pointers and count ← 0, `overflow` ← 0, all queued words are discarded. Memory contents are not reset.

## Timing
- Reset values: `down_valid`=0, `empty`=1, `full`=0, `almost_full`=0 (for almost_full_level ≥ 1), `count`=0, `overflow`=0. `down_data` is undefined.
- Write-to-read latency: a word pushed at edge N is visible on `down_data` with `down_valid`=1 in the cycle after edge N. There is no same-cycle bypass.
- A pop at edge N presents the next word, or deasserts `down_valid`, in the cycle after edge N.
- Throughput: one push and one pop per cycle, sustained indefinitely at any occupancy from 1 to depth.
- `overflow` rises in the cycle after the dropping edge and then stays high.
- `down_valid` never depends combinationally on `down_ready`. `down_data` and `down_valid` stay stable while `down_valid`=1 and `down_ready`=0.

## Test plan
- Reset, then 3 pushes 0x11, 0x22, 0x33 with `down_ready`=0 → count=3, `down_data`=0x11, `empty`=0. Then `down_ready`=1 for 3 cycles → outputs 0x11, 0x22, 0x33 in order, then `empty`=1 and count=0.
- Fill depth=8 with 0x00..0x07 while `down_ready`=0 → `full`=1, `almost_full`=1 from count=6. Push 0xAA with no pop → `overflow`=1, count stays 8, and the drained sequence is 0x00..0x07 with 0xAA absent.
- Full FIFO, `up_valid`=1 with 0xBB and `down_ready`=1 in the same cycle → count stays 8, `overflow` stays 0, and 0xBB appears after 0x07 in the output stream.
- depth=5: stream 20 words 1..20 with both sides active every cycle → outputs are 1..20 in order with no gaps after the first-word latency. This exercises repeated wrap of non-power-of-two pointers.
- Random `up_valid` (60%) and `down_ready` (50%) over 2000 cycles against a queue model → data order, count, full/empty and overflow all match the model.
- Assert `rst`=0 asynchronously between clock edges while count=4 and `overflow`=1 → all outputs return to their reset values immediately. After release, a single push of 0x5C is read out as the first word.
